pdm_audio_tx: RTL and testbench
===============================

// Module: pdm_audio_tx
// PURPOSE
//  Playback-side counterpart of the PDM microphone capture path: converts signed PCM samples into
//  a 1-bit PDM stream for a speaker/Class-D output, driving its own bit clock.
//  PCM arrives through a valid/ready handshake from the playback FIFO.
//  Each sample is held for OSR bit periods.
// PARAMETERS
//  DIV_HALF  50  clk cycles per bclk half-period (100 MHz clk -> 1 MHz bclk)
//  OSR       64  bclk periods per PCM sample (1 MHz / 64 = 15.625 kS/s)
//  WIDTH     16  PCM sample width, two's complement
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high
//  en            in   1      run enable; low = idle
//  sample_in     in   WIDTH  signed PCM sample
//  sample_valid  in   1      sample_in valid
//  sample_rdy    out  1      holding buffer empty; transfer when valid&rdy on clk edge
//  bclk          out  1      PDM bit clock, 50% duty
//  pdm_out       out  1      PDM data; changes only on bclk falling edge
//  underrun      out  1      1-clk pulse: frame boundary with empty buffer
// BEHAVIOUR
//  Reset: bclk=0, pdm_out=0, underrun=0, buffer empty (sample_rdy=1), active sample=0.
//   Counters=0, modulator state=0. Reset mid-stream aborts immediately, with no partial frame.
//  en=0: div/bit counters held at 0, bclk=0, pdm_out=0, modulator state cleared.
//   The buffer still accepts one sample.
//  Divider: div_cnt counts 0..DIV_HALF-1; at DIV_HALF-1 it wraps to 0 and bclk toggles.
//   First rising bclk is DIV_HALF clks after en rises.
//  Bit step (clk edge where bclk toggles 1->0): modulator advances with the active sample and
//   pdm_out registers the new bit, so data is stable across the next rising edge.
//   bit_cnt increments mod OSR.
//  Frame boundary (bit step where bit_cnt wraps OSR-1 -> 0):
//   buffer full: active <= buffer; buffer empties; new sample is used from the next bit step.
//   buffer empty: active unchanged (repeat last sample); underrun=1 for that clk.
//   valid&rdy on the same clk as the boundary: the boundary sees the buffer empty (underrun).
//   The incoming sample is stored for the next frame.
//  sample_rdy = ~buffer_full, registered-state based; no combinational path from sample_valid.
//  Modulator, first order (default), error feedback:
//   u = {~sample[W-1], sample[W-2:0]} (offset binary)
//   s = acc + u  (W+1 bits); pdm bit = s[W]; acc <= s[W-1:0]
//   Ones density = u/2^W: 0x0000 -> 1/2; 0x8000 -> all 0; 0x7FFF -> 65535/65536.
// CONFIGURATION
//  PDM_TX_ORDER2_EN defined: 2nd-order modulator replaces 1st order.
//   fb = prev_bit ? +2^(W-1) : -2^(W-1)
//   i1 += x - fb;  i2 += i1 - fb  (i1 W+2 bits, i2 W+4 bits, signed)
//   bit = (i2 >= 0)
//   Inputs are clipped to +/-(2^(W-1)-2^(W-3)) before summing, which keeps the loop stable.
//  Not defined: 1st-order error-feedback modulator only; no clipping.
//  Handshake, timing and ports are identical in both builds.
// TESTING
//  1 reset, en=1, no samples: bclk period 100 clk; pdm_out toggles 0101..; underrun every 6400 clk.
//  2 sample 0x4000 sustained (1st order): 48 ones per 64-bit frame, +/-1.
//    sample 0x8000 gives 0 ones; 0x0000 gives 32 ones.
//  3 valid held high: exactly one accept per 64 bits, no underrun, sample order preserved.
//  4 valid&rdy on the boundary clk: underrun pulses, old sample repeats, new sample used next frame.
//  5 reset asserted mid-frame: next clk bclk=0, pdm_out=0, sample_rdy=1; stream restarts cleanly.
//  6 PDM_TX_ORDER2_EN, 0x6000 for 64 frames: mean density 0.875 +/- 0.02; |i2| bounded.

Source files
------------

// File: rtl/pdm_audio_tx.sv
//------------------------------------------------------------------------------
// pdm_audio_tx : signed PCM -> 1-bit PDM transmitter with its own bit clock.
// Define PDM_TX_ORDER2_EN for the 2nd-order modulator.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pdm_audio_tx #(
  parameter int DIV_HALF = 50,
  parameter int OSR      = 64,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_rdy,
  output logic             bclk,
  output logic             pdm_out,
  output logic             underrun
);

  localparam int c_DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int c_BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic               r_bclk;
  logic               r_pdm;
  logic               r_underrun;
  logic               r_buf_full;
  logic [WIDTH-1:0]   r_buf;
  logic [WIDTH-1:0]   r_active;

  logic w_div_wrap;
  logic w_bit_step;
  logic w_frame_end;
  logic w_accept;
  logic w_mod_bit;

  assign w_div_wrap  = en && (r_div_cnt == c_DIV_W'(DIV_HALF - 1));
  // A bit step is the clk edge on which bclk falls.
  assign w_bit_step  = w_div_wrap && r_bclk;
  assign w_frame_end = w_bit_step && (r_bit_cnt == c_BIT_W'(OSR - 1));
  assign w_accept    = sample_valid && !r_buf_full;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_bit_step)
        r_bit_cnt <= w_frame_end ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // Load and accept are exclusive: load needs a full buffer, accept an empty one,
  // so a sample arriving on the boundary clk waits for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_active   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_end && !r_buf_full;
      if (w_frame_end && r_buf_full) begin
        r_active   <= r_buf;
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf      <= sample_in;
        r_buf_full <= 1'b1;
      end
    end
  end

`ifdef PDM_TX_ORDER2_EN
  localparam int c_I1_W = WIDTH + 2;
  localparam int c_I2_W = WIDTH + 4;
  localparam logic signed [c_I1_W-1:0] c_CLIP = c_I1_W'((2 ** (WIDTH - 1)) - (2 ** (WIDTH - 3)));
  localparam logic signed [c_I1_W-1:0] c_FB   = c_I1_W'(2 ** (WIDTH - 1));

  logic signed [c_I1_W-1:0] r_i1;
  logic signed [c_I2_W-1:0] r_i2;
  logic signed [c_I1_W-1:0] w_x;
  logic signed [c_I1_W-1:0] w_xc;
  logic signed [c_I1_W-1:0] w_fb;
  logic signed [c_I1_W-1:0] w_i1_nxt;
  logic signed [c_I2_W-1:0] w_i2_nxt;

  // Clipping to 3/4 full scale keeps both integrators bounded.
  always_comb begin
    w_x  = c_I1_W'($signed(r_active));
    w_xc = w_x;
    if (w_x > c_CLIP)
      w_xc = c_CLIP;
    else if (w_x < -c_CLIP)
      w_xc = -c_CLIP;
    w_fb     = r_pdm ? c_FB : -c_FB;
    w_i1_nxt = r_i1 + w_xc - w_fb;
    w_i2_nxt = r_i2 + c_I2_W'(w_i1_nxt) - c_I2_W'(w_fb);
  end

  assign w_mod_bit = ~w_i2_nxt[c_I2_W-1];

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_i1 <= '0;
      r_i2 <= '0;
    end else if (w_bit_step) begin
      r_i1 <= w_i1_nxt;
      r_i2 <= w_i2_nxt;
    end
  end
`else
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   w_sum;

  // Offset-binary input: the carry out of the accumulator is the PDM bit.
  assign w_sum     = {1'b0, r_acc} + {1'b0, ~r_active[WIDTH-1], r_active[WIDTH-2:0]};
  assign w_mod_bit = w_sum[WIDTH];

  always_ff @(posedge clk) begin
    if (reset || !en)
      r_acc <= '0;
    else if (w_bit_step)
      r_acc <= w_sum[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || !en)
      r_pdm <= 1'b0;
    else if (w_bit_step)
      r_pdm <= w_mod_bit;
  end

  assign sample_rdy = ~r_buf_full;
  assign bclk       = r_bclk;
  assign pdm_out    = r_pdm;
  assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_pdm_audio_tx.sv
//------------------------------------------------------------------------------
// tb_pdm_audio_tx : directed, table-driven self-checking bench for pdm_audio_tx.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pdm_audio_tx;

  localparam int DIV_HALF  = 50;
  localparam int OSR       = 64;
  localparam int WIDTH     = 16;
  localparam int FRAME_CLK = 2 * DIV_HALF * OSR;
  localparam int NV        = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_rdy;
  logic             bclk;
  logic             pdm_out;
  logic             underrun;

  pdm_audio_tx #(.DIV_HALF(DIV_HALF), .OSR(OSR), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_rdy   (sample_rdy),
    .bclk         (bclk),
    .pdm_out      (pdm_out),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sample;
    int               lo;
    int               hi;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  int   cyc, bits, ones, ur_cycles, first_rise, first_ur;
  int   frame_ones [16];
  int   ur_at_bnd  [16];
  logic [15:0] bit_hist;
  logic prev_bclk;

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic mon_clear();
    cyc = 0; bits = 0; ones = 0; ur_cycles = 0;
    first_rise = -1; first_ur = -1; bit_hist = '0; prev_bclk = bclk;
    for (int i = 0; i < 16; i++) begin
      frame_ones[i] = -1;
      ur_at_bnd[i]  = -1;
    end
  endtask

  // One clk: observe on the falling clk edge, count bits at each bclk fall.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (underrun) begin
      ur_cycles++;
      if (first_ur < 0) first_ur = cyc;
    end
    if (!prev_bclk && bclk && first_rise < 0) first_rise = cyc;
    if (prev_bclk && !bclk) begin
      bits++;
      if (bits <= 16) bit_hist[bits-1] = pdm_out;
      ones += int'(pdm_out);
      if (bits % OSR == 0) begin
        if (bits / OSR < 16) begin
          frame_ones[bits/OSR] = ones;
          ur_at_bnd[bits/OSR]  = int'(underrun);
        end
        ones = 0;
      end
    end
    prev_bclk = bclk;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mon_clear();
  endtask

  vec_t vecs [NV];
  int   idx, accepts, acc1_cyc, found, i2_max;
  bit   xfer;

  initial begin
`ifdef PDM_TX_ORDER2_EN
    vecs[0] = '{16'h4000, 44, 52};
    vecs[1] = '{16'h8000,  4, 12};
    vecs[2] = '{16'hC000, 12, 20};
    vecs[3] = '{16'h7FFF, 52, 60};
`else
    vecs[0] = '{16'h4000, 48, 48};
    vecs[1] = '{16'h8000,  0,  0};
    vecs[2] = '{16'hC000, 16, 16};
    vecs[3] = '{16'h7FFF, 63, 64};
`endif

    // Reset state, then en=0 still accepts exactly one sample
    reset = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
    @(negedge clk);
    check("rst_bclk", int'(bclk), 0, 0);
    check("rst_pdm", int'(pdm_out), 0, 0);
    check("rst_underrun", int'(underrun), 0, 0);
    check("rst_rdy", int'(sample_rdy), 1, 1);
    reset = 1'b0;
    sample_in = 16'h1234; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("idle_accept_rdy", int'(sample_rdy), 0, 0);
    repeat (120) @(negedge clk);
    check("idle_bclk", int'(bclk), 0, 0);

    // No samples: bclk timing, alternating bits, underrun at each boundary
    do_reset();
    en = 1'b1;
    while (cyc < FRAME_CLK + 10) step();
    check("t1_first_rise", first_rise, DIV_HALF, DIV_HALF);
`ifndef PDM_TX_ORDER2_EN
    check("t1_bits_0101", int'(bit_hist[7:0]), 8'hAA, 8'hAA);
`endif
    check("t1_first_ur_cyc", first_ur, FRAME_CLK, FRAME_CLK);
    check("t1_ur_pulse_len", ur_cycles, 1, 1);
    check("t1_frame1_ones", frame_ones[1], 30, 34);

`ifdef PDM_TX_ORDER2_EN
    // Sustained 0x6000 through the 2nd-order loop
    do_reset();
    en = 1'b1; sample_in = 16'h6000; sample_valid = 1'b1;
    i2_max = 0;
    while (cyc < 5 * FRAME_CLK + 50) begin
      step();
      if (dut.r_i2 > i2_max) i2_max = int'(dut.r_i2);
      if (-dut.r_i2 > i2_max) i2_max = int'(-dut.r_i2);
    end
    sample_valid = 1'b0;
    check("t6_density_x256", frame_ones[2] + frame_ones[3] + frame_ones[4] + frame_ones[5],
          224 - 5, 224 + 5);
    check("t6_i2_bound", i2_max, 0, 2 ** (WIDTH + 1));
    check("t6_no_underrun", ur_cycles, 0, 0);
`else
    // Valid held high: one accept per frame, order preserved, underrun after table ends
    do_reset();
    en = 1'b1; idx = 0; accepts = 0; acc1_cyc = -1;
    sample_in = vecs[0].sample; sample_valid = 1'b1;
    while (cyc < (NV + 1) * FRAME_CLK + 50) begin
      xfer = sample_valid && sample_rdy;
      step();
      if (xfer) begin
        if (accepts == 1) acc1_cyc = cyc;
        accepts++; idx++;
        if (idx < NV) sample_in = vecs[idx].sample;
        else begin sample_valid = 1'b0; sample_in = '0; end
      end
    end
    check("t3_frame1_ones", frame_ones[1], 32, 32);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("t2_frame%0d_ones_%h", i + 2, vecs[i].sample), frame_ones[i+2],
            vecs[i].lo, vecs[i].hi);
      check($sformatf("t3_bnd%0d_underrun", i + 1), ur_at_bnd[i+1], 0, 0);
    end
    check("t3_bnd_last_underrun", ur_at_bnd[NV+1], 1, 1);
    check("t3_accepts", accepts, NV, NV);
    check("t3_second_accept_cyc", acc1_cyc, FRAME_CLK + 1, FRAME_CLK + 1);
`endif

    // valid&rdy on the boundary clk: underrun, old sample repeats, new one next frame
    do_reset();
    en = 1'b1;
    while (cyc < FRAME_CLK - 1) step();
    check("t4_rdy_before", int'(sample_rdy), 1, 1);
    sample_in = 16'h8000; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0; sample_in = '0;
    check("t4_underrun", int'(underrun), 1, 1);
    check("t4_stored", int'(sample_rdy), 0, 0);
    while (cyc < 3 * FRAME_CLK + 50) step();
`ifdef PDM_TX_ORDER2_EN
    check("t4_frame2_repeat", frame_ones[2], 28, 36);
    check("t4_frame3_new", frame_ones[3], 4, 12);
`else
    check("t4_frame2_repeat", frame_ones[2], 32, 32);
    check("t4_frame3_new", frame_ones[3], 0, 0);
`endif
    check("t4_bnd2_underrun", ur_at_bnd[2], 0, 0);

    // Reset mid-frame while bclk and pdm_out are high and the buffer is full
    do_reset();
    en = 1'b1; sample_in = 16'h4000; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    found = 0;
    while (found == 0 && cyc < 4000) begin
      step();
      if (cyc >= 3000 && bclk && pdm_out && !sample_rdy) found = 1;
    end
    check("t5_precondition", found, 1, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_bclk", int'(bclk), 0, 0);
    check("t5_pdm", int'(pdm_out), 0, 0);
    check("t5_rdy", int'(sample_rdy), 1, 1);
    reset = 1'b0;
    mon_clear();
    while (cyc < 900) step();
    check("t5_restart_rise", first_rise, DIV_HALF, DIV_HALF);
`ifndef PDM_TX_ORDER2_EN
    check("t5_restart_bits", int'(bit_hist[7:0]), 8'hAA, 8'hAA);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
